// File: rtl/spec_readout.sv
// Spectrum readout: streams accumulated bins 1..num_bins from the accumulator DPRAM into
// the upload FIFO, clearing each location after it is read. Define BG_SUB_EN to subtract the background spectrum.
module spec_readout #(
  parameter int IDX_W      = 10,
  parameter int N_POINTS   = 1024,
  parameter int BIN_W      = 4,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int OBUF_DEPTH = 4,
  parameter int ADDR_W     = BIN_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIN_W-1:0]  num_bins,
  output logic [ADDR_W-1:0] rdaddr_out,
  input  logic [DATA_W-1:0] rddata_in,
  output logic [IDX_W-1:0]  bg_rdaddr_out,
  input  logic [DATA_W-1:0] bg_rddata_in,
  output logic              clr_wea,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for start
  // ISSUE  | issuing reads while output credit is available
  // DRAIN  | all reads issued, waiting for returns and buffer to empty
  // FINISH | one-cycle done pulse

`ifdef BG_SUB_EN
  localparam int LAT = RD_LAT + 1;
`else
  localparam int LAT = RD_LAT;
`endif
  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(OBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  nb_q, nb_d, bin_q, bin_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LAT-1:0]    vld_q;
  logic [ADDR_W-1:0] tag_q [LAT];
  logic [CNT_W-1:0]  infl_q, cnt_q;
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [DATA_W-1:0] buf_q [OBUF_DEPTH];
  logic [DATA_W-1:0] push_data;
  logic              issue, push, pop, credit, last;

  // Buffer occupancy plus reads in flight bounds the buffer, so it can never overflow.
  assign credit = ({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_C;
  assign last   = (bin_q == nb_q) && (idx_q == LAST_IDX);
  assign push   = vld_q[LAT-1];
  assign pop    = out_valid && out_ready;

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? buf_q[rd_q] : '0;
  assign clr_wea   = vld_q[LAT-1];
  assign clr_addr  = tag_q[LAT-1];
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    bin_d   = bin_q;
    idx_d   = idx_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nb_d    = num_bins;
          bin_d   = BIN_W'(1);
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (nb_q == '0) begin
          state_d = FINISH;
        end else if (credit) begin
          issue = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            bin_d = bin_q + BIN_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_q == '0 && cnt_q == '0) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      nb_q       <= '0;
      bin_q      <= '0;
      idx_q      <= '0;
      rdaddr_out <= '0;
      vld_q      <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      infl_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
      if (issue) rdaddr_out <= {bin_q, idx_q};
      vld_q[0] <= issue;
      tag_q[0] <= {bin_q, idx_q};
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      infl_q <= infl_q + CNT_W'(issue) - CNT_W'(push);
      cnt_q  <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_q] <= push_data;
  end

`ifdef BG_SUB_EN
  logic [DATA_W-1:0] sub_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q         <= '0;
      bg_rdaddr_out <= '0;
    end else begin
      sub_q <= (rddata_in >= bg_rddata_in) ? (rddata_in - bg_rddata_in) : '0;
      if (issue) bg_rdaddr_out <= idx_q;
    end
  end
  assign push_data = sub_q;
`else
  logic unused_bg;
  assign unused_bg     = ^bg_rddata_in;
  assign bg_rdaddr_out = '0;
  assign push_data     = rddata_in;
`endif

endmodule

// File: tb/tb_spec_readout.sv
// Scoreboard bench for spec_readout with N_POINTS=8: expected words and clear addresses
// are queued when a readout is started and compared as the DUT produces them.
module tb_spec_readout;
  localparam int IDX_W = 10, NP = 8, BIN_W = 4, DATA_W = 32, ADDR_W = 14;

  logic              clk, rst, start, out_ready;
  logic [BIN_W-1:0]  num_bins;
  logic [ADDR_W-1:0] rdaddr_out, clr_addr;
  logic [IDX_W-1:0]  bg_rdaddr_out;
  logic [DATA_W-1:0] rddata_in, bg_rddata_in, out_data;
  logic              clr_wea, out_valid, busy, done;

  spec_readout #(.IDX_W(IDX_W), .N_POINTS(NP), .BIN_W(BIN_W), .DATA_W(DATA_W),
                 .RD_LAT(2), .OBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .num_bins(num_bins),
    .rdaddr_out(rdaddr_out), .rddata_in(rddata_in),
    .bg_rdaddr_out(bg_rdaddr_out), .bg_rddata_in(bg_rddata_in),
    .clr_wea(clr_wea), .clr_addr(clr_addr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_cnt = 0, rx_cnt = 0, clr_cnt = 0, vld_cycles = 0;
  bit bg_mode = 1'b0, bg_addr_seen = 1'b0, prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] clr_q[$];

  // Registered-read RAM models; accumulator content is bin*100+idx unless bg_mode.
  function automatic logic [DATA_W-1:0] acc_val(input logic [ADDR_W-1:0] a);
    if (bg_mode) return a[0] ? 32'd10 : 32'd50;
    return 32'(a[13:10]) * 32'd100 + 32'(a[9:0]);
  endfunction

  function automatic logic [DATA_W-1:0] bg_val(input logic [IDX_W-1:0] i);
`ifdef BG_SUB_EN
    if (bg_mode) return i[0] ? 32'd40 : 32'd20;
    return 32'd0;
`else
    return 32'hA5A5_0000 | 32'(i);
`endif
  endfunction

  always @(posedge clk) begin
    rddata_in    <= acc_val(rdaddr_out);
    bg_rddata_in <= bg_val(bg_rdaddr_out);
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: out_valid=%0b out_data=%0d required %0d", out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid) vld_cycles++;
      if (out_valid && out_ready) begin
        rx_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_extra: got %0d, required no word", out_data);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL word: got %0d required %0d", out_data, e);
          end
        end
      end
      if (clr_wea) begin
        clr_cnt++;
        checks++;
        if (clr_q.size() == 0) begin
          errors++;
          $display("FAIL clr_extra: clr_addr=%0h, required no clear", clr_addr);
        end else begin
          logic [ADDR_W-1:0] ea;
          ea = clr_q.pop_front();
          if (clr_addr !== ea) begin
            errors++;
            $display("FAIL clr_addr: got %0h required %0h", clr_addr, ea);
          end
        end
      end
      if (done) done_cnt++;
      if (bg_rdaddr_out != '0) bg_addr_seen = 1'b1;
    end
  end

  task automatic queue_frame(input int nb);
    for (int b = 1; b <= nb; b++) begin
      for (int i = 0; i < NP; i++) begin
        if (bg_mode) exp_q.push_back((i % 2 == 0) ? 32'd30 : 32'd0);
        else         exp_q.push_back(32'(b * 100 + i));
        clr_q.push_back(ADDR_W'(b * 1024 + i));
      end
    end
  endtask

  task automatic pulse_start(input int nb);
    start    = 1'b1;
    num_bins = BIN_W'(nb);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic run_until_done(input bit bp, input int budget);
    int d0, cyc;
    d0  = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_bins = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, clr_wea, busy, done} !== 4'b0000 || rdaddr_out !== '0 ||
        clr_addr !== '0 || out_data !== '0 || bg_rdaddr_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b clr=%0b busy=%0b done=%0b rdaddr=%0h, required all 0",
               out_valid, clr_wea, busy, done, rdaddr_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b valid=%0b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    int d0, r0, c0, lat;
    d0 = done_cnt; r0 = rx_cnt; c0 = clr_cnt;
    queue_frame(2);
    pulse_start(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %0b required 1", busy);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL first_latency: got %0d cycles required 4", lat);
    end
    run_until_done(1'b0, 400);
    checks++;
    if (done_cnt != d0 + 1 || rx_cnt != r0 + 16 || clr_cnt != c0 + 16) begin
      errors++;
      $display("FAIL basic_counts: done=%0d words=%0d clears=%0d required 1 16 16",
               done_cnt - d0, rx_cnt - r0, clr_cnt - c0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %0b required 0", busy);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0 || clr_q.size() != 0) begin
      errors++;
      $display("FAIL basic_tail: done=%0d pending_words=%0d pending_clears=%0d required 1 0 0",
               done_cnt - d0, exp_q.size(), clr_q.size());
    end
  endtask

  task automatic test_backpressure();
    int d0, r0;
    d0 = done_cnt; r0 = rx_cnt;
    queue_frame(2);
    pulse_start(2);
    run_until_done(1'b1, 400);
    checks++;
    if (done_cnt != d0 + 1 || rx_cnt != r0 + 16 || exp_q.size() != 0 || clr_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure: done=%0d words=%0d pending=%0d required 1 16 0",
               done_cnt - d0, rx_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_zero_bins();
    int r0, c0, v0, d0;
    logic [ADDR_W-1:0] a0;
    r0 = rx_cnt; c0 = clr_cnt; v0 = vld_cycles; d0 = done_cnt; a0 = rdaddr_out;
    pulse_start(0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_early: done=%0b one cycle after start, required 0", done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done_timing: done=%0b two cycles after start, required 1", done);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rdaddr_out !== a0 || clr_cnt != c0 || vld_cycles != v0 || rx_cnt != r0 ||
        done_cnt != d0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_bins: rdaddr=%0h/%0h clears=%0d valids=%0d dones=%0d busy=%0b required no activity, 1 done",
               rdaddr_out, a0, clr_cnt - c0, vld_cycles - v0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int d0, r0;
    d0 = done_cnt; r0 = rx_cnt;
    queue_frame(2);
    pulse_start(2);
    repeat (6) @(posedge clk);
    #1;
    pulse_start(5);
    run_until_done(1'b0, 400);
    checks++;
    if (done_cnt != d0 + 1 || rx_cnt != r0 + 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_ignored: done=%0d words=%0d pending=%0d required 1 16 0",
               done_cnt - d0, rx_cnt - r0, exp_q.size());
    end
    r0 = rx_cnt;
    queue_frame(3);
    pulse_start(3);
    run_until_done(1'b0, 400);
    checks++;
    if (rx_cnt != r0 + 24 || exp_q.size() != 0 || clr_q.size() != 0) begin
      errors++;
      $display("FAIL next_start_bins: words=%0d pending=%0d required 24 0", rx_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int r0, t, d0;
    r0 = rx_cnt;
    queue_frame(2);
    pulse_start(2);
    t = 0;
    while (rx_cnt < r0 + 5 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (rx_cnt < r0 + 5) begin
      errors++;
      $display("FAIL reset_mid_wait: words=%0d required 5 before reset", rx_cnt - r0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, clr_wea, busy, done} !== 4'b0000 || rdaddr_out !== '0 ||
        clr_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: valid=%0b clr=%0b busy=%0b done=%0b rdaddr=%0h required all 0",
               out_valid, clr_wea, busy, done, rdaddr_out);
    end
    exp_q.delete();
    clr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt; r0 = rx_cnt;
    queue_frame(1);
    pulse_start(1);
    run_until_done(1'b0, 400);
    checks++;
    if (done_cnt != d0 + 1 || rx_cnt != r0 + 8 || exp_q.size() != 0 || clr_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_readout: done=%0d words=%0d pending=%0d required 1 8 0",
               done_cnt - d0, rx_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_bg_path();
`ifdef BG_SUB_EN
    int r0;
    r0 = rx_cnt;
    bg_mode = 1'b1;
    queue_frame(2);
    pulse_start(2);
    run_until_done(1'b1, 400);
    checks++;
    if (rx_cnt != r0 + 16 || exp_q.size() != 0 || clr_q.size() != 0) begin
      errors++;
      $display("FAIL bg_sub: words=%0d pending=%0d required 16 0", rx_cnt - r0, exp_q.size());
    end
    bg_mode = 1'b0;
`else
    checks++;
    if (bg_addr_seen) begin
      errors++;
      $display("FAIL bg_addr_idle: bg_rdaddr_out went nonzero, required held at 0");
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_bins();
    test_start_while_busy();
    test_reset_mid();
    test_bg_path();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
